// File: rtl/x7seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner for a 3-digit BCD reading.
// The reading is snapshotted once per frame, and a registered threshold alarm drives the status digit and blink.
module x7seg_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int BLINK_DIV = 60,
  parameter int THRESH    = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x,
  input  logic       blink_en,
  output logic [6:0] smg_duan,
  output logic [3:0] smg_wei,
  output logic       dp,
  output logic       alarm,
  output logic [9:0] value
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PSC_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PSC_BLANK = PW'(BLANK_CYC);
  localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_DIV - 1);
  localparam logic [9:0]    THRESH_V  = 10'(THRESH);

  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_E;
    endcase
    return s;
  endfunction

  function automatic logic bcd_valid(input logic [9:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic logic [9:0] bcd_value(input logic [9:0] b);
    return (10'(b[9:8]) * 10'd100) + (10'(b[7:4]) * 10'd10) + 10'(b[3:0]);
  endfunction

  logic [PW-1:0] psc_q, psc_d;
  logic [1:0]    idx_q, idx_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          phase_q, phase_d;
  logic [9:0]    snap_q, snap_d;
  logic          snap_valid_q, snap_valid_d;
  logic [9:0]    value_q, value_d;
  logic          alarm_q, alarm_d;
  logic [6:0]    duan_q, duan_d;
  logic [3:0]    wei_q, wei_d;
  logic          tc_s, wrap_s, off_s;
  logic [6:0]    glyph_s;

  // Scan timing, frame snapshot, blink phase and alarm next-state
  always_comb begin
    tc_s         = (psc_q == PSC_LAST);
    wrap_s       = tc_s && (idx_q == 2'd3);
    psc_d        = tc_s ? '0 : psc_q + PW'(1);
    idx_d        = tc_s ? idx_q + 2'd1 : idx_q;
    snap_d       = snap_q;
    snap_valid_d = snap_valid_q;
    value_d      = value_q;
    frm_d        = frm_q;
    phase_d      = phase_q;
    if (wrap_s) begin
      snap_d       = x;
      snap_valid_d = 1'b1;
      value_d      = bcd_value(x);
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d   = frm_q + FW'(1);
        phase_d = phase_q;
      end
    end else begin
      snap_d = snap_q;
    end
    alarm_d = snap_valid_q && bcd_valid(snap_q) && (value_q <= THRESH_V);
  end

  // Glyph and enable selection for the slot currently being scanned
  always_comb begin
    case (idx_q)
      2'd0: glyph_s = seg_of(snap_q[3:0]);
      2'd1: glyph_s = (snap_q[9:4] == 6'd0) ? SEG_BLANK : seg_of(snap_q[7:4]);
      2'd2: glyph_s = (snap_q[9:8] == 2'd0) ? SEG_BLANK : seg_of({2'b00, snap_q[9:8]});
      2'd3: glyph_s = alarm_q ? SEG_L : SEG_BLANK;
      default: glyph_s = SEG_BLANK;
    endcase
    // The blink phase runs freely; blink_en only gates its effect, so dropping it shows at once.
    off_s = !snap_valid_q || (psc_q < PSC_BLANK) || (blink_en && alarm_q && !phase_q);
    if (off_s) begin
      wei_d  = 4'hF;
      duan_d = SEG_BLANK;
    end else begin
      wei_d  = ~(4'b0001 << idx_q);
      duan_d = glyph_s;
    end
  end

  // State and registered-output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q        <= '0;
      idx_q        <= 2'd0;
      frm_q        <= '0;
      phase_q      <= 1'b1;
      snap_q       <= 10'd0;
      snap_valid_q <= 1'b0;
      value_q      <= 10'd0;
      alarm_q      <= 1'b0;
      duan_q       <= SEG_BLANK;
      wei_q        <= 4'hF;
    end else begin
      psc_q        <= psc_d;
      idx_q        <= idx_d;
      frm_q        <= frm_d;
      phase_q      <= phase_d;
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
      value_q      <= value_d;
      alarm_q      <= alarm_d;
      duan_q       <= duan_d;
      wei_q        <= wei_d;
    end
  end

  assign smg_duan = duan_q;
  assign smg_wei  = wei_q;
  assign dp       = 1'b1;
  assign alarm    = alarm_q;
  assign value    = value_q;

endmodule

// File: tb/tb_x7seg_scan_ctrl.sv
// Scoreboard bench: a time-indexed reference model pushes per-cycle expectations and a monitor pops and compares them.
module tb_x7seg_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BD = 2;
  localparam int TH = 60;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       blink_en = 1'b0;
  logic [9:0] x = 10'd0;
  logic [6:0] smg_duan;
  logic [3:0] smg_wei;
  logic       dp;
  logic       alarm;
  logic [9:0] value;

  x7seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD), .THRESH(TH)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .blink_en(blink_en),
    .smg_duan(smg_duan), .smg_wei(smg_wei), .dp(dp), .alarm(alarm), .value(value)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] duan;
    logic [3:0] wei;
    logic       dp;
    logic       alarm;
    logic [9:0] value;
  } out_t;

  out_t        exp_q[$];
  logic [10:0] hist[$];   // {valid, bcd} snapshot held after each clock edge since reset
  int          k = 0;     // clock edges since reset release
  int          n_chk = 0;
  int          n_pass = 0;
  logic [6:0]  gly [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic int val_of(input logic [10:0] h);
    return int'(h[9:8]) * 100 + int'(h[7:4]) * 10 + int'(h[3:0]);
  endfunction

  function automatic bit rule(input logic [10:0] h);
    return h[10] && (h[7:4] <= 4'd9) && (h[3:0] <= 4'd9) && (val_of(h) <= TH);
  endfunction

  function automatic logic [6:0] dig(input logic [3:0] d);
    return (d <= 4'd9) ? gly[d] : 7'h06;
  endfunction

  // Outputs visible after edge kk reflect the scan position reached after kk-1 edges.
  function automatic out_t expect_after(input int kk, input bit be);
    out_t        e;
    int          s, psc, idx;
    bit          a_prev, ph_on;
    logic [10:0] hs;
    logic [3:0]  one;
    s      = kk - 1;
    hs     = hist[s];
    a_prev = (s >= 1) ? rule(hist[s-1]) : 1'b0;
    psc    = s % SD;
    idx    = (s / SD) % 4;
    ph_on  = (((s / FRAME) / BD) % 2) == 0;
    one    = 4'b0001;
    e.dp    = 1'b1;
    e.alarm = rule(hist[kk-1]);
    e.value = 10'(val_of(hist[kk]));
    if (!hs[10] || psc < BC || (be && a_prev && !ph_on)) begin
      e.wei  = 4'hF;
      e.duan = 7'h7F;
    end else begin
      e.wei = ~(one << idx);
      case (idx)
        0: e.duan = dig(hs[3:0]);
        1: e.duan = (hs[9:8] == 2'd0 && hs[7:4] == 4'd0) ? 7'h7F : dig(hs[7:4]);
        2: e.duan = (hs[9:8] == 2'd0) ? 7'h7F : gly[hs[9:8]];
        default: e.duan = a_prev ? 7'h47 : 7'h7F;
      endcase
    end
    return e;
  endfunction

  // Reference model: records the snapshot history and queues the expected outputs.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        hist.delete();
        hist.push_back(11'h000);
        k = 0;
        exp_q.delete();
      end else begin
        k++;
        if (k % FRAME == 0) hist.push_back({1'b1, x});
        else hist.push_back(hist[k-1]);
        exp_q.push_back(expect_after(k, blink_en));
      end
    end
  end

  // Monitor: compares every presented output cycle against the queued expectation.
  initial begin
    out_t e, got;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {smg_duan, smg_wei, dp, alarm, value};
        n_chk++;
        if (got === e) n_pass++;
        else $display("FAIL scan k=%0d got duan=%h wei=%h dp=%b alarm=%b value=%0d expected duan=%h wei=%h dp=%b alarm=%b value=%0d",
                      k, got.duan, got.wei, got.dp, got.alarm, got.value,
                      e.duan, e.wei, e.dp, e.alarm, e.value);
      end
    end
  end

  task automatic check_reset(input string name);
    out_t got, e;
    got = {smg_duan, smg_wei, dp, alarm, value};
    e   = {7'h7F, 4'hF, 1'b1, 1'b0, 10'd0};
    n_chk++;
    if (got === e) n_pass++;
    else $display("FAIL %s got=%h expected=%h", name, got, e);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    run(3);
    #1 check_reset("reset_state");
    @(negedge clk);
    #2 rst_n = 1'b1;
    run(3 * FRAME);
    x = 10'h125;
    run(2 * FRAME + 20);
    x = 10'h059;
    run(2 * FRAME);
    x = 10'h0A3;
    run(2 * FRAME);
    x = 10'h045;
    blink_en = 1'b1;
    run(6 * FRAME);
    found = 1'b0;
    for (int i = 0; i < 4 * FRAME && !found; i++) begin
      @(negedge clk);
      if ((((k / FRAME) / BD) % 2) == 1 && (k % SD) == 5) found = 1'b1;
    end
    n_chk++;
    if (found) n_pass++;
    else $display("FAIL blink_off_wait got=not_found expected=found");
    blink_en = 1'b0;
    run(FRAME);
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 1) == 1)
        x = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else
        x = 10'($urandom);
      blink_en = 1'($urandom_range(0, 1));
      run($urandom_range(5, 70));
    end
    x = 10'h245;
    blink_en = 1'b0;
    run(2 * FRAME);
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (((k / SD) % 4) == 2 && (k % SD) == 4) found = 1'b1;
    end
    n_chk++;
    if (found) n_pass++;
    else $display("FAIL idx2_wait got=not_found expected=found");
    #2 rst_n = 1'b0;
    #1 check_reset("reset_mid_slot");
    run(3);
    #2 rst_n = 1'b1;
    x = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    run(3 * FRAME);
    n_chk++;
    if (n_chk > 1000) n_pass++;
    else $display("FAIL monitor_activity got=%0d expected=>1000", n_chk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
